// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with rs/rt forwarding, ALU operand build and load-use bubble insertion.
// Latency: one cycle from decode inputs to registered E* outputs; DSTALL is combinational.
// Backpressure: HOLD freezes the register; FLUSH or a load-use stall loads a bubble instead.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [3:0]    DALUC,
  input  logic [DW-1:0] DQA,
  input  logic [DW-1:0] DQB,
  input  logic [DW-1:0] DIMM,
  input  logic [DW-1:0] DPC4,
  input  logic [RW-1:0] DRS,
  input  logic [RW-1:0] DRT,
  input  logic [RW-1:0] DRN,
  input  logic          DUSERS,
  input  logic          DUSERT,
  input  logic          DALUIMM,
  input  logic          DSHIFT,
  input  logic          DJAL,
  input  logic          DWREG,
  input  logic          DM2REG,
  input  logic          DWMEM,
  input  logic [DW-1:0] EXALU,
  input  logic          MWREG,
  input  logic [RW-1:0] MRN,
  input  logic [DW-1:0] MDATA,
  input  logic          WWREG,
  input  logic [RW-1:0] WRN,
  input  logic [DW-1:0] WDATA,
  input  logic          HOLD,
  input  logic          FLUSH,
  output logic [3:0]    EALUC,
  output logic [DW-1:0] EXA,
  output logic [DW-1:0] EXB,
  output logic [DW-1:0] ESTD,
  output logic [RW-1:0] ERN,
  output logic          EWREG,
  output logic          EM2REG,
  output logic          EWMEM,
  output logic          DSTALL
);

  // A bubble is an add with no side effects, so EALUC idles at the add encoding.
  localparam logic [3:0]    ALU_ADD = 4'b0010;
  localparam logic [DW-1:0] FOUR    = DW'(4);

  logic [DW-1:0] fa;
  logic [DW-1:0] fb;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic          ex_fwd_ok;
  logic          ex_load;

  // The EX result is only usable for ALU ops; a load's data is not ready until MEM.
  assign ex_fwd_ok = EWREG && !EM2REG && (ERN != '0);
  assign ex_load   = EWREG && EM2REG && (ERN != '0);

  // Load-use hazard: decode needs a register that the load in EX has not yet fetched.
  assign DSTALL = ex_load && ((DUSERS && (ERN == DRS)) || (DUSERT && (ERN == DRT)));

  // rs forwarding, nearest producer wins; register 0 is never forwarded.
  always_comb begin
    fa = DQA;
    if (ex_fwd_ok && (ERN == DRS)) begin
      fa = EXALU;
    end else if (MWREG && (MRN != '0) && (MRN == DRS)) begin
      fa = MDATA;
    end else if (WWREG && (WRN != '0) && (WRN == DRS)) begin
      fa = WDATA;
    end
  end

  // rt forwarding, same priority as rs.
  always_comb begin
    fb = DQB;
    if (ex_fwd_ok && (ERN == DRT)) begin
      fb = EXALU;
    end else if (MWREG && (MRN != '0) && (MRN == DRT)) begin
      fb = MDATA;
    end else if (WWREG && (WRN != '0) && (WRN == DRT)) begin
      fb = WDATA;
    end
  end

  // Operand build: jal links PC+8, shifts take rt as the shifted value and shamt via DIMM.
  always_comb begin
    opa = fa;
    opb = DALUIMM ? DIMM : fb;
    if (DJAL) begin
      opa = DPC4 + FOUR;
      opb = '0;
    end else if (DSHIFT) begin
      opa = fb;
      opb = DIMM;
    end
  end

  // Pipeline register: HOLD freezes, FLUSH/stall inject a bubble, otherwise load decode.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      EALUC  <= ALU_ADD;
      EXA    <= '0;
      EXB    <= '0;
      ESTD   <= '0;
      ERN    <= '0;
      EWREG  <= 1'b0;
      EM2REG <= 1'b0;
      EWMEM  <= 1'b0;
    end else if (!HOLD) begin
      if (FLUSH || DSTALL) begin
        EALUC  <= ALU_ADD;
        EXA    <= '0;
        EXB    <= '0;
        ESTD   <= '0;
        ERN    <= '0;
        EWREG  <= 1'b0;
        EM2REG <= 1'b0;
        EWMEM  <= 1'b0;
      end else begin
        EALUC  <= DALUC;
        EXA    <= opa;
        EXB    <= opb;
        ESTD   <= fb;
        ERN    <= DRN;
        EWREG  <= DWREG;
        EM2REG <= DM2REG;
        EWMEM  <= DWMEM;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random traffic.
// A behavioural model tracks the expected EX-stage contents and is compared after every edge.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after the edge.
module tb_id_ex_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  DALUC;
  logic [31:0] DQA, DQB, DIMM, DPC4;
  logic [4:0]  DRS, DRT, DRN;
  logic        DUSERS, DUSERT, DALUIMM, DSHIFT, DJAL, DWREG, DM2REG, DWMEM;
  logic [31:0] EXALU;
  logic        MWREG;
  logic [4:0]  MRN;
  logic [31:0] MDATA;
  logic        WWREG;
  logic [4:0]  WRN;
  logic [31:0] WDATA;
  logic        HOLD, FLUSH;
  logic [3:0]  EALUC;
  logic [31:0] EXA, EXB, ESTD;
  logic [4:0]  ERN;
  logic        EWREG, EM2REG, EWMEM, DSTALL;

  int nchecks = 0;
  int nerr    = 0;

  // Model of the EX-stage register contents.
  logic [3:0]  m_aluc;
  logic [31:0] m_a, m_b, m_std;
  logic [4:0]  m_rn;
  logic        m_wreg, m_m2reg, m_wmem;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .CLK(CLK), .RST(RST), .DALUC(DALUC), .DQA(DQA), .DQB(DQB), .DIMM(DIMM), .DPC4(DPC4),
    .DRS(DRS), .DRT(DRT), .DRN(DRN), .DUSERS(DUSERS), .DUSERT(DUSERT), .DALUIMM(DALUIMM),
    .DSHIFT(DSHIFT), .DJAL(DJAL), .DWREG(DWREG), .DM2REG(DM2REG), .DWMEM(DWMEM),
    .EXALU(EXALU), .MWREG(MWREG), .MRN(MRN), .MDATA(MDATA), .WWREG(WWREG), .WRN(WRN),
    .WDATA(WDATA), .HOLD(HOLD), .FLUSH(FLUSH), .EALUC(EALUC), .EXA(EXA), .EXB(EXB),
    .ESTD(ESTD), .ERN(ERN), .EWREG(EWREG), .EM2REG(EM2REG), .EWMEM(EWMEM), .DSTALL(DSTALL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_bubble();
    m_aluc = 4'b0010; m_a = 0; m_b = 0; m_std = 0;
    m_rn = 0; m_wreg = 0; m_m2reg = 0; m_wmem = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".ealuc"},  {28'd0, EALUC},  {28'd0, m_aluc});
    chk({tag, ".exa"},    EXA,             m_a);
    chk({tag, ".exb"},    EXB,             m_b);
    chk({tag, ".estd"},   ESTD,            m_std);
    chk({tag, ".ern"},    {27'd0, ERN},    {27'd0, m_rn});
    chk({tag, ".ewreg"},  {31'd0, EWREG},  {31'd0, m_wreg});
    chk({tag, ".em2reg"}, {31'd0, EM2REG}, {31'd0, m_m2reg});
    chk({tag, ".ewmem"},  {31'd0, EWMEM},  {31'd0, m_wmem});
  endtask

  // Value an operand register should see: newest in-flight writer, else the regfile.
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return rf;
    if (m_wreg && !m_m2reg && m_rn == r) return EXALU;
    if (MWREG && MRN == r) return MDATA;
    if (WWREG && WRN == r) return WDATA;
    return rf;
  endfunction

  function automatic logic model_stall();
    if (!(m_wreg && m_m2reg) || m_rn == 0) return 1'b0;
    return (DUSERS && DRS == m_rn) || (DUSERT && DRT == m_rn);
  endfunction

  task automatic clr_in();
    DALUC = 4'b0010; DQA = 0; DQB = 0; DIMM = 0; DPC4 = 0;
    DRS = 0; DRT = 0; DRN = 0; DUSERS = 0; DUSERT = 0; DALUIMM = 0;
    DSHIFT = 0; DJAL = 0; DWREG = 0; DM2REG = 0; DWMEM = 0;
    EXALU = 0; MWREG = 0; MRN = 0; MDATA = 0; WWREG = 0; WRN = 0; WDATA = 0;
    HOLD = 0; FLUSH = 0;
  endtask

  // One clock: check the stall flag, predict the register update, clock, compare.
  task automatic cycle(input string tag);
    logic        st;
    logic [31:0] a, b, s;
    #1;
    st = model_stall();
    chk({tag, ".dstall"}, {31'd0, DSTALL}, {31'd0, st});
    s = operand(DRT, DQB);
    if (DJAL) begin
      a = DPC4 + 32'd4; b = 0;
    end else if (DSHIFT) begin
      a = s; b = DIMM;
    end else begin
      a = operand(DRS, DQA); b = DALUIMM ? DIMM : s;
    end
    @(posedge CLK);
    if (HOLD) begin
      // keep model as is
    end else if (FLUSH || st) begin
      model_bubble();
    end else begin
      m_aluc = DALUC; m_a = a; m_b = b; m_std = s; m_rn = DRN;
      m_wreg = DWREG; m_m2reg = DM2REG; m_wmem = DWMEM;
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    clr_in();
    RST = 1'b1;
    model_bubble();
    #2;
    chk_all("reset0");
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // EX forwarding: add $3 in EX, next instruction reads $3.
    DRN = 3; DWREG = 1; DQA = 32'h7; DQB = 32'h9;
    cycle("ex_prod");
    clr_in();
    DRS = 3; DUSERS = 1; DQA = 32'h5; EXALU = 32'h10; DRN = 6; DWREG = 1;
    cycle("ex_fwd");
    chk("ex_fwd.const", EXA, 32'h10);

    // Priority EX > MEM > WB on rt=$4.
    clr_in();
    DRN = 4; DWREG = 1;
    cycle("pri_prod");
    clr_in();
    DRT = 4; DUSERT = 1; DQB = 32'hdead; EXALU = 32'h1;
    MWREG = 1; MRN = 4; MDATA = 32'h2; WWREG = 1; WRN = 4; WDATA = 32'h3;
    cycle("pri_ex");
    chk("pri_ex.const", EXB, 32'h1);
    // MEM beats WB once EX no longer matches.
    DRT = 4; DRN = 0; DWREG = 0;
    cycle("pri_mem");
    chk("pri_mem.const", EXB, 32'h2);
    // Everyone writing $0: nothing forwarded.
    clr_in();
    DRN = 0; DWREG = 1;
    cycle("r0_prod");
    clr_in();
    DRT = 0; DUSERT = 1; DQB = 32'habc; EXALU = 32'h1;
    MWREG = 1; MRN = 0; MDATA = 32'h2; WWREG = 1; WRN = 0; WDATA = 32'h3;
    cycle("r0");
    chk("r0.const", EXB, 32'habc);

    // Load-use: lw $5 then a reader of $5.
    clr_in();
    DRN = 5; DWREG = 1; DM2REG = 1;
    cycle("lw");
    clr_in();
    DRS = 5; DUSERS = 1; DQA = 32'h11; DRN = 7; DWREG = 1;
    #1;
    chk("lu.stall1", {31'd0, DSTALL}, 32'd1);
    cycle("lu_bubble");
    chk("lu.bubble_wreg", {31'd0, EWREG}, 32'd0);
    MWREG = 1; MRN = 5; MDATA = 32'h77;
    #1;
    chk("lu.stall0", {31'd0, DSTALL}, 32'd0);
    cycle("lu_mem");
    chk("lu.mem_fwd", EXA, 32'h77);

    // Shift and jal operand forms.
    clr_in();
    DSHIFT = 1; DQB = 32'h1; DIMM = 32'h80; DQA = 32'h55; DRN = 8; DWREG = 1;
    cycle("shift");
    chk("shift.a", EXA, 32'h1);
    chk("shift.b", EXB, 32'h80);
    clr_in();
    DJAL = 1; DPC4 = 32'h0040_0004; DALUC = 4'b0100; DRN = 31; DWREG = 1; DQA = 32'h99;
    cycle("jal");
    chk("jal.a", EXA, 32'h0040_0008);
    chk("jal.b", EXB, 32'h0);
    // PC+4 wraps modulo 2^32.
    DPC4 = 32'hffff_fffe;
    cycle("jal_wrap");
    chk("jal_wrap.a", EXA, 32'h2);

    // HOLD beats FLUSH, then FLUSH alone bubbles.
    clr_in();
    DALUC = 4'b0110; DQA = 32'h1234; DQB = 32'h5678; DRN = 9; DWREG = 1; DWMEM = 1;
    cycle("pre_hold");
    HOLD = 1; FLUSH = 1; DQA = 32'hffff;
    cycle("hold1");
    cycle("hold2");
    chk("hold.a", EXA, 32'h1234);
    HOLD = 0;
    cycle("flush");
    chk("flush.ewreg", {31'd0, EWREG}, 32'd0);

    // Mid-run async reset.
    clr_in();
    DALUC = 4'b0111; DQA = 32'h42; DRN = 10; DWREG = 1; DM2REG = 1;
    cycle("pre_rst");
    RST = 1'b1;
    model_bubble();
    #2;
    chk_all("rst_mid");
    chk("rst_mid.ealuc", {28'd0, EALUC}, 32'h2);
    RST = 1'b0;
    cycle("post_rst");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      DALUC = 4'($urandom);  DQA = $urandom; DQB = $urandom; DIMM = $urandom; DPC4 = $urandom;
      DRS = 5'($urandom_range(0, 7)); DRT = 5'($urandom_range(0, 7)); DRN = 5'($urandom_range(0, 7));
      DUSERS = 1'($urandom); DUSERT = 1'($urandom); DALUIMM = 1'($urandom);
      DSHIFT = ($urandom_range(0, 5) == 0); DJAL = ($urandom_range(0, 7) == 0);
      DWREG = 1'($urandom); DM2REG = ($urandom_range(0, 2) == 0); DWMEM = 1'($urandom);
      EXALU = $urandom; MWREG = 1'($urandom); MRN = 5'($urandom_range(0, 7)); MDATA = $urandom;
      WWREG = 1'($urandom); WRN = 5'($urandom_range(0, 7)); WDATA = $urandom;
      HOLD = ($urandom_range(0, 7) == 0); FLUSH = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
